// File: rtl/johnson_decoder_checker_pkg.sv
// Shared definitions for the Johnson decoder/checker: FSM states, counter widths,
// and the index-width helper so decoder, checker and interface all agree.
// Pure declarations; no latency or backpressure.
package johnson_decoder_checker_pkg;

  localparam int ERR_CNT_W = 8;   // saturating error counter width
  localparam int GOOD_W    = 4;   // good-successor counter, covers LOCK_CNT 1..15

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } jdc_state_e;

  // Index width for an n-stage Johnson code (2n legal codes)
  function automatic int jdc_iw(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/johnson_decoder_checker_if.sv
// Bundles the Johnson code input and the decoded/status outputs of the checker.
// master: code source side (drives jc_in/jc_valid, observes results).
// slave : checker side (samples code, drives dec_*, locked, seq_err, illegal, err_cnt).
interface johnson_decoder_checker_if
  import johnson_decoder_checker_pkg::*;
#(
  parameter int N = 4
);
  localparam int IW = jdc_iw(N);

  logic [N-1:0]         jc_in;
  logic                 jc_valid;
  logic [IW-1:0]        dec_idx;
  logic [2*N-1:0]       dec_oh;
  logic                 dec_valid;
  logic                 locked;
  logic                 seq_err;
  logic                 illegal;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output jc_in, jc_valid,
    input  dec_idx, dec_oh, dec_valid, locked, seq_err, illegal, err_cnt
  );

  modport slave (
    input  jc_in, jc_valid,
    output dec_idx, dec_oh, dec_valid, locked, seq_err, illegal, err_cnt
  );

endinterface

// File: rtl/johnson_decoder_checker_decode.sv
// Combinational Johnson code decoder: jc_i -> {legal_o, idx_o, oh_o}.
// Latency 0; no state, no backpressure.
// Ports: jc_i (N-bit code), legal_o (code in the 2N set), idx_o (0..2N-1), oh_o (one-hot or 0).
module johnson_decoder_checker_decode
  import johnson_decoder_checker_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          jc_i,
  output logic                  legal_o,
  output logic [jdc_iw(N)-1:0]  idx_o,
  output logic [2*N-1:0]        oh_o
);
  localparam int IW = jdc_iw(N);

  logic [N-1:0] code_k;

  // Enumerate every legal code of a shift-left Johnson counter and match against it.
  // k <= N : k ones filled from the LSB; k > N : (2N-k) ones left at the MSB end.
  always_comb begin
    legal_o = 1'b0;
    idx_o   = '0;
    code_k  = '0;
    for (int k = 0; k < 2 * N; k++) begin
      if (k <= N) code_k = N'((1 << k) - 1);
      else        code_k = ~N'((1 << (k - N)) - 1);
      if (jc_i == code_k) begin
        legal_o = 1'b1;
        idx_o   = IW'(k);
      end
    end
    oh_o = legal_o ? ((2 * N)'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/johnson_decoder_checker.sv
// Decodes a sampled Johnson code and checks it follows the legal successor sequence.
// Latency: all outputs registered, update on the clk edge that samples jc_valid=1.
// No backpressure: every valid sample is consumed; jc_valid=0 freezes all state.
// Ports: clk, rst (async, active-high); bus (slave modport) carries jc_in/jc_valid in
// and dec_idx/dec_oh/dec_valid/locked/seq_err/illegal/err_cnt out.
module johnson_decoder_checker
  import johnson_decoder_checker_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter bit RESYNC   = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  johnson_decoder_checker_if.slave bus
);
  localparam int                IW     = jdc_iw(N);
  localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_CNT);

  logic           dc_legal;
  logic [IW-1:0]  dc_idx;
  logic [2*N-1:0] dc_oh;

  johnson_decoder_checker_decode #(.N(N)) u_decode (
    .jc_i    (bus.jc_in),
    .legal_o (dc_legal),
    .idx_o   (dc_idx),
    .oh_o    (dc_oh)
  );

  jdc_state_e           state_q, state_d;
  logic [GOOD_W-1:0]    good_q, good_d;
  logic [IW-1:0]        idx_q, idx_d;      // doubles as the previous legal index
  logic [2*N-1:0]       oh_q, oh_d;
  logic                 dvld_q, dvld_d;
  logic                 seq_err_q, seq_err_d;
  logic                 illegal_q, illegal_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 is_succ;
  logic                 is_resync;

  // Expected successor wraps explicitly so non-power-of-two 2N also works
  assign is_succ   = (dc_idx == ((idx_q == IW'(2 * N - 1)) ? '0 : idx_q + 1'b1));
  assign is_resync = RESYNC && (bus.jc_in == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_SEARCH;
      good_q    <= '0;
      idx_q     <= '0;
      oh_q      <= '0;
      dvld_q    <= 1'b0;
      seq_err_q <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      idx_q     <= idx_d;
      oh_q      <= oh_d;
      dvld_q    <= dvld_d;
      seq_err_q <= seq_err_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    idx_d     = idx_q;
    oh_d      = oh_q;
    dvld_d    = bus.jc_valid;
    seq_err_d = 1'b0;
    illegal_d = 1'b0;

    if (bus.jc_valid) begin
      if (!dc_legal) begin
        // Index holds its last legal value; one-hot shows "no code"
        state_d   = ST_SEARCH;
        good_d    = '0;
        oh_d      = '0;
        illegal_d = 1'b1;
      end else begin
        idx_d = dc_idx;
        oh_d  = dc_oh;
        unique case (state_q)
          ST_SEARCH: begin
            state_d = ST_ACQ;
            good_d  = '0;
          end
          ST_ACQ: begin
            if (is_succ) begin
              good_d = good_q + 1'b1;
              if (good_d == LOCK_C) state_d = ST_LOCKED;
            end else begin
              good_d = '0;          // restart acquisition from the new index
            end
          end
          ST_LOCKED: begin
            if (!is_succ) begin
              good_d = '0;
              if (is_resync) begin
                state_d = ST_ACQ;   // upstream counter was reset, not a fault
              end else begin
                state_d   = ST_SEARCH;
                seq_err_d = 1'b1;
              end
            end
          end
          default: begin
            state_d = ST_SEARCH;
            good_d  = '0;
          end
        endcase
      end
    end

    err_d = err_q;
    if ((seq_err_d || illegal_d) && (err_q != '1)) err_d = err_q + 1'b1;
  end

  assign bus.dec_idx   = idx_q;
  assign bus.dec_oh    = oh_q;
  assign bus.dec_valid = dvld_q;
  assign bus.locked    = (state_q == ST_LOCKED);
  assign bus.seq_err   = seq_err_q;
  assign bus.illegal   = illegal_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// Directed bench for johnson_decoder_checker (N=4, LOCK_CNT=3, RESYNC=1).
// Vector table for lock/wrap/illegal/seq-error/resync/stall, then hand sequences
// for async reset, an upstream counter reset and error-counter saturation.
module tb_johnson_decoder_checker;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  johnson_decoder_checker_if #(.N(4)) bus ();

  johnson_decoder_checker #(.N(4), .LOCK_CNT(3), .RESYNC(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] code;
    logic       vld;
    int         idx;
    logic [7:0] oh;
    logic       dv;
    logic       lk;
    logic       se;
    logic       il;
    int         err;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;

  task automatic add(input logic [3:0] c, input logic v, input int idx, input logic [7:0] oh,
                     input logic dv, input logic lk, input logic se, input logic il, input int err);
    vec_t r;
    r = '{code: c, vld: v, idx: idx, oh: oh, dv: dv, lk: lk, se: se, il: il, err: err};
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int row, input int idx, input logic [7:0] oh,
                           input logic dv, input logic lk, input logic se, input logic il, input int err);
    chk({tag, ".dec_idx"},   row, 32'(bus.dec_idx),   32'(idx));
    chk({tag, ".dec_oh"},    row, 32'(bus.dec_oh),    32'(oh));
    chk({tag, ".dec_valid"}, row, 32'(bus.dec_valid), 32'(dv));
    chk({tag, ".locked"},    row, 32'(bus.locked),    32'(lk));
    chk({tag, ".seq_err"},   row, 32'(bus.seq_err),   32'(se));
    chk({tag, ".illegal"},   row, 32'(bus.illegal),   32'(il));
    chk({tag, ".err_cnt"},   row, 32'(bus.err_cnt),   32'(err));
  endtask

  // Drive one sample between edges, then settle just after the sampling edge
  task automatic drv(input logic [3:0] c, input logic v);
    @(negedge clk);
    bus.jc_in    = c;
    bus.jc_valid = v;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] cnt;
  int         exp_k;

  initial begin
    rst          = 1'b1;
    bus.jc_in    = 4'b0000;
    bus.jc_valid = 1'b0;

    //   code     v  idx  oh     dv lk se il err
    add(4'b0000, 1, 0, 8'h01, 1, 0, 0, 0, 0);  // SEARCH -> ACQ
    add(4'b0001, 1, 1, 8'h02, 1, 0, 0, 0, 0);
    add(4'b0011, 1, 2, 8'h04, 1, 0, 0, 0, 0);
    add(4'b0111, 1, 3, 8'h08, 1, 1, 0, 0, 0);  // third successor: lock
    add(4'b1111, 1, 4, 8'h10, 1, 1, 0, 0, 0);
    add(4'b1110, 1, 5, 8'h20, 1, 1, 0, 0, 0);
    add(4'b1100, 1, 6, 8'h40, 1, 1, 0, 0, 0);
    add(4'b1000, 1, 7, 8'h80, 1, 1, 0, 0, 0);
    add(4'b0000, 1, 0, 8'h01, 1, 1, 0, 0, 0);  // wrap 7 -> 0
    add(4'b0001, 1, 1, 8'h02, 1, 1, 0, 0, 0);
    add(4'b0101, 1, 1, 8'h00, 1, 0, 0, 1, 1);  // illegal: idx holds
    add(4'b0011, 1, 2, 8'h04, 1, 0, 0, 0, 1);  // SEARCH -> ACQ
    add(4'b0011, 1, 2, 8'h04, 1, 0, 0, 0, 1);  // repeat in ACQ: restart, no error
    add(4'b0111, 1, 3, 8'h08, 1, 0, 0, 0, 1);
    add(4'b1111, 1, 4, 8'h10, 1, 0, 0, 0, 1);
    add(4'b1110, 1, 5, 8'h20, 1, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      add(4'b0101, 0, 5, 8'h20, 0, 1, 0, 0, 1); // stalled valid: everything holds
    add(4'b1100, 1, 6, 8'h40, 1, 1, 0, 0, 1);
    add(4'b1000, 1, 7, 8'h80, 1, 1, 0, 0, 1);
    add(4'b0000, 1, 0, 8'h01, 1, 1, 0, 0, 1);
    add(4'b0001, 1, 1, 8'h02, 1, 1, 0, 0, 1);
    add(4'b0011, 1, 2, 8'h04, 1, 1, 0, 0, 1);
    add(4'b1110, 1, 5, 8'h20, 1, 0, 1, 0, 2);  // wrong successor while locked
    add(4'b1100, 1, 6, 8'h40, 1, 0, 0, 0, 2);
    add(4'b1000, 1, 7, 8'h80, 1, 0, 0, 0, 2);
    add(4'b0000, 1, 0, 8'h01, 1, 0, 0, 0, 2);
    add(4'b0001, 1, 1, 8'h02, 1, 1, 0, 0, 2);
    add(4'b0011, 1, 2, 8'h04, 1, 1, 0, 0, 2);
    add(4'b0000, 1, 0, 8'h01, 1, 0, 0, 0, 2);  // resync from 0011, no error
    add(4'b0001, 1, 1, 8'h02, 1, 0, 0, 0, 2);
    add(4'b0011, 1, 2, 8'h04, 1, 0, 0, 0, 2);
    add(4'b0111, 1, 3, 8'h08, 1, 1, 0, 0, 2);  // relocked after 3 successors
    add(4'b1111, 1, 4, 8'h10, 1, 1, 0, 0, 2);
    add(4'b1111, 1, 4, 8'h10, 1, 0, 1, 0, 3);  // stalled counter breaks lock
    add(4'b1010, 1, 4, 8'h00, 1, 0, 0, 1, 4);  // illegal while searching

    #2;
    check_out("reset", 0, 0, 8'h00, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drv(vecs[i].code, vecs[i].vld);
      check_out("vec", i, vecs[i].idx, vecs[i].oh, vecs[i].dv, vecs[i].lk,
                vecs[i].se, vecs[i].il, vecs[i].err);
    end

    // Relock, then assert reset between clock edges: outputs must clear at once
    drv(4'b0000, 1);
    drv(4'b0001, 1);
    drv(4'b0011, 1);
    drv(4'b0111, 1);
    check_out("relock", 0, 3, 8'h08, 1, 1, 0, 0, 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 0, 0, 8'h00, 0, 0, 0, 0, 0);
    bus.jc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drv(4'b0011, 1);
    check_out("post_rst", 0, 2, 8'h04, 1, 0, 0, 0, 0);
    drv(4'b0111, 1);
    check_out("post_rst", 1, 3, 8'h08, 1, 0, 0, 0, 0);
    drv(4'b1111, 1);
    check_out("post_rst", 2, 4, 8'h10, 1, 0, 0, 0, 0);
    drv(4'b1110, 1);
    check_out("post_rst", 3, 5, 8'h20, 1, 1, 0, 0, 0);

    // Upstream counter reset mid-run: held at 0000 for two cycles, then free-runs
    drv(4'b1100, 1);
    check_out("cnt_rst", 0, 6, 8'h40, 1, 1, 0, 0, 0);
    drv(4'b0000, 1);
    check_out("cnt_rst", 1, 0, 8'h01, 1, 0, 0, 0, 0);
    drv(4'b0000, 1);
    check_out("cnt_rst", 2, 0, 8'h01, 1, 0, 0, 0, 0);
    cnt   = 4'b0000;
    exp_k = 0;
    for (int i = 0; i < 10; i++) begin
      cnt   = {cnt[2:0], ~cnt[3]};
      exp_k = (exp_k + 1) % 8;
      drv(cnt, 1);
      chk("free_run.dec_idx", i, 32'(bus.dec_idx), 32'(exp_k));
      chk("free_run.locked",  i, 32'(bus.locked),  (i >= 2) ? 32'd1 : 32'd0);
      chk("free_run.err_cnt", i, 32'(bus.err_cnt), 32'd0);
    end

    // Error counter saturation
    for (int i = 1; i <= 300; i++) begin
      drv((i % 2 == 1) ? 4'b0101 : 4'b1010, 1);
      chk("sat.err_cnt", i, 32'(bus.err_cnt), (i < 255) ? 32'(i) : 32'd255);
      chk("sat.illegal", i, 32'(bus.illegal), 32'd1);
    end
    check_out("sat_end", 0, 2, 8'h00, 1, 0, 0, 1, 255);

    drv(4'b0000, 0);
    check_out("idle", 0, 2, 8'h00, 0, 0, 0, 0, 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
